hazard_tracker: RTL and testbench

HAZARD_TRACKER -- requirements
Module: hazard_tracker

---
 rtl/hazard_tracker.sv | 88 ++++++++
 tb/tb_hazard_tracker.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_tracker.sv
// Data-hazard tracker for a 5-stage pipeline: follows in-flight writers through E/M/W
// using Tnew/Tuse timing and produces the stall request and per-operand forwarding selects.
module hazard_tracker (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [4:0]  D_Rs_In,
    input  logic [4:0]  D_Rt_In,
    input  logic        D_Use_Rs_In,
    input  logic        D_Use_Rt_In,
    input  logic [1:0]  D_Tuse_Rs_In,
    input  logic [1:0]  D_Tuse_Rt_In,
    input  logic [1:0]  D_Tnew_In,
    input  logic [4:0]  D_Wr_Addr_In,
    input  logic        D_RegWrite_In,
    output logic        Stall_Out,
    output logic [1:0]  Fwd_Rs_Out,
    output logic [1:0]  Fwd_Rt_Out,
    output logic [15:0] Stall_Count_Out
);

    typedef struct packed {
        logic       valid;
        logic [4:0] addr;
        logic [1:0] tnew;
    } entry_t;

    entry_t     e_q;
    entry_t     m_q;
    entry_t     w_q;
    logic [2:0] rs_res;
    logic [2:0] rt_res;

    function automatic logic [1:0] dec_tnew(input logic [1:0] t);
        return (t == 2'd0) ? 2'd0 : t - 2'd1;
    endfunction

    function automatic logic hit(input entry_t x, input logic rd_en, input logic [4:0] r);
        return x.valid && rd_en && (r != 5'd0) && (x.addr == r);
    endfunction

    // Result is {blocked, fwd_sel}; only the nearest matching stage decides, so a
    // younger writer still computing hides an older one that could have forwarded.
    function automatic logic [2:0] resolve(input logic rd_en, input logic [4:0] r,
                                           input logic [1:0] tuse, input entry_t e,
                                           input entry_t m, input entry_t w);
        logic [2:0] res;
        res = 3'b000;
        if (hit(e, rd_en, r)) begin
            res = {e.tnew > tuse, (e.tnew == 2'd0) ? 2'd1 : 2'd0};
        end else if (hit(m, rd_en, r)) begin
            res = {m.tnew > tuse, (m.tnew == 2'd0) ? 2'd2 : 2'd0};
        end else if (hit(w, rd_en, r)) begin
            res = {w.tnew > tuse, (w.tnew == 2'd0) ? 2'd3 : 2'd0};
        end
        return res;
    endfunction

    always_comb begin
        rs_res = resolve(D_Use_Rs_In, D_Rs_In, D_Tuse_Rs_In, e_q, m_q, w_q);
        rt_res = resolve(D_Use_Rt_In, D_Rt_In, D_Tuse_Rt_In, e_q, m_q, w_q);
    end

    assign Stall_Out  = rs_res[2] | rt_res[2];
    assign Fwd_Rs_Out = rs_res[1:0];
    assign Fwd_Rt_Out = rt_res[1:0];

    always_ff @(posedge Clk) begin
        if (Reset) begin
            e_q             <= '0;
            m_q             <= '0;
            w_q             <= '0;
            Stall_Count_Out <= 16'd0;
        end else begin
            if (Stall_Out) begin
                e_q <= '0;
            end else begin
                e_q <= {D_RegWrite_In && (D_Wr_Addr_In != 5'd0), D_Wr_Addr_In, D_Tnew_In};
            end
            // M and W advance even while D is frozen, which is what releases a stall.
            m_q <= {e_q.valid, e_q.addr, dec_tnew(e_q.tnew)};
            w_q <= {m_q.valid, m_q.addr, dec_tnew(m_q.tnew)};
            if (Stall_Out && (Stall_Count_Out != 16'hFFFF)) begin
                Stall_Count_Out <= Stall_Count_Out + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_tracker.sv
// Bench for hazard_tracker: a reference model of in-flight writers by age feeds a
// scoreboard queue; directed hazard scenarios, counter saturation and random traffic.
module tb_hazard_tracker;

    logic        Clk;
    logic        Reset;
    logic [4:0]  d_rs;
    logic [4:0]  d_rt;
    logic        d_urs;
    logic        d_urt;
    logic [1:0]  d_tuse_rs;
    logic [1:0]  d_tuse_rt;
    logic [1:0]  d_tnew;
    logic [4:0]  d_wr;
    logic        d_rw;
    logic        Stall_Out;
    logic [1:0]  Fwd_Rs_Out;
    logic [1:0]  Fwd_Rt_Out;
    logic [15:0] Stall_Count_Out;

    hazard_tracker dut (
        .Clk             (Clk),
        .Reset           (Reset),
        .D_Rs_In         (d_rs),
        .D_Rt_In         (d_rt),
        .D_Use_Rs_In     (d_urs),
        .D_Use_Rt_In     (d_urt),
        .D_Tuse_Rs_In    (d_tuse_rs),
        .D_Tuse_Rt_In    (d_tuse_rt),
        .D_Tnew_In       (d_tnew),
        .D_Wr_Addr_In    (d_wr),
        .D_RegWrite_In   (d_rw),
        .Stall_Out       (Stall_Out),
        .Fwd_Rs_Out      (Fwd_Rs_Out),
        .Fwd_Rt_Out      (Fwd_Rt_Out),
        .Stall_Count_Out (Stall_Count_Out)
    );

    // clock / reset
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // model: slot k holds the writer that left D k+1 edges ago, with its Tnew as issued
    logic        hv [3];
    logic [4:0]  ha [3];
    logic [1:0]  ht [3];
    logic [15:0] mcnt;

    // scoreboard
    logic [20:0] exp_q[$];
    int          n_vec;
    int          n_err;
    logic        want_en;
    logic [4:0]  want_v;
    logic        want_cnt_en;
    logic [15:0] want_cnt_v;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [2:0] model_op(input logic u, input logic [4:0] r,
                                            input logic [1:0] tuse);
        logic [2:0] res;
        logic       found;
        int         rem;
        res   = 3'b000;
        found = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (!found && hv[k] && u && (r != 5'd0) && (ha[k] == r)) begin
                found = 1'b1;
                rem   = int'(ht[k]) - k;
                if (rem < 0) rem = 0;
                res = {rem > int'(tuse), (rem == 0) ? 2'(k + 1) : 2'd0};
            end
        end
        return res;
    endfunction

    // driver tasks
    task automatic set_d(input logic [4:0] rs, input logic urs, input logic [1:0] tu_rs,
                         input logic [4:0] rt, input logic urt, input logic [1:0] tu_rt,
                         input logic [4:0] wr, input logic rw, input logic [1:0] tnew);
        d_rs = rs; d_urs = urs; d_tuse_rs = tu_rs;
        d_rt = rt; d_urt = urt; d_tuse_rt = tu_rt;
        d_wr = wr; d_rw = rw; d_tnew = tnew;
    endtask

    task automatic nop();
        set_d(5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0);
    endtask

    task automatic want(input logic st, input logic [1:0] frs, input logic [1:0] frt);
        want_en = 1'b1;
        want_v  = {st, frs, frt};
    endtask

    task automatic want_cnt(input logic [15:0] c);
        want_cnt_en = 1'b1;
        want_cnt_v  = c;
    endtask

    // One clock: push expectations, compare at negedge, advance the model at posedge.
    task automatic cycle(input logic quiet);
        logic [2:0]  ors;
        logic [2:0]  ort;
        logic        st;
        logic [20:0] ev;
        ors = model_op(d_urs, d_rs, d_tuse_rs);
        ort = model_op(d_urt, d_rt, d_tuse_rt);
        st  = ors[2] | ort[2];
        if (!quiet) begin
            exp_q.push_back({st, ors[1:0], ort[1:0], mcnt});
            if (want_en || want_cnt_en) begin
                exp_q.push_back({want_en ? want_v : {st, ors[1:0], ort[1:0]},
                                 want_cnt_en ? want_cnt_v : mcnt});
            end
        end
        @(negedge Clk);
        while (exp_q.size() > 0) begin
            ev = exp_q.pop_front();
            check("stall",  32'(Stall_Out),       32'(ev[20]));
            check("fwd_rs", 32'(Fwd_Rs_Out),      32'(ev[19:18]));
            check("fwd_rt", 32'(Fwd_Rt_Out),      32'(ev[17:16]));
            check("count",  32'(Stall_Count_Out), 32'(ev[15:0]));
        end
        @(posedge Clk);
        if (Reset) begin
            for (int k = 0; k < 3; k++) begin
                hv[k] = 1'b0; ha[k] = 5'd0; ht[k] = 2'd0;
            end
            mcnt = 16'd0;
        end else begin
            hv[2] = hv[1]; ha[2] = ha[1]; ht[2] = ht[1];
            hv[1] = hv[0]; ha[1] = ha[0]; ht[1] = ht[0];
            if (st) begin
                hv[0] = 1'b0; ha[0] = 5'd0; ht[0] = 2'd0;
            end else begin
                hv[0] = d_rw && (d_wr != 5'd0); ha[0] = d_wr; ht[0] = d_tnew;
            end
            if (st && (mcnt != 16'hFFFF)) mcnt = mcnt + 16'd1;
        end
        want_en     = 1'b0;
        want_cnt_en = 1'b0;
        #1;
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        want_en = 1'b0; want_cnt_en = 1'b0; want_v = '0; want_cnt_v = '0;
        for (int k = 0; k < 3; k++) begin
            hv[k] = 1'b0; ha[k] = 5'd0; ht[k] = 2'd0;
        end
        mcnt  = 16'd0;
        Reset = 1'b1;
        nop();
        repeat (2) @(posedge Clk);
        #1;

        // reset state, still in reset
        want(1'b0, 2'd0, 2'd0); want_cnt(16'd0); cycle(1'b0);
        Reset = 1'b0;

        // lw $8 then beq $8: two stall cycles, then forward from W
        set_d(5'd29, 1'b1, 2'd1, 5'd0, 1'b0, 2'd0, 5'd8, 1'b1, 2'd2);
        want(1'b0, 2'd0, 2'd0); cycle(1'b0);
        set_d(5'd8, 1'b1, 2'd0, 5'd0, 1'b1, 2'd0, 5'd0, 1'b0, 2'd0);
        want(1'b1, 2'd0, 2'd0); cycle(1'b0);
        want(1'b1, 2'd0, 2'd0); cycle(1'b0);
        want(1'b0, 2'd3, 2'd0); want_cnt(16'd2); cycle(1'b0);

        // addu $9 then sw using $9 late: no stall, no forward yet
        set_d(5'd1, 1'b1, 2'd1, 5'd2, 1'b1, 2'd1, 5'd9, 1'b1, 2'd1);
        cycle(1'b0);
        set_d(5'd29, 1'b1, 2'd1, 5'd9, 1'b1, 2'd2, 5'd0, 1'b0, 2'd0);
        want(1'b0, 2'd0, 2'd0); cycle(1'b0);
        // addu $9, two nops, reader of $9 -> forward from W
        set_d(5'd1, 1'b1, 2'd1, 5'd2, 1'b1, 2'd1, 5'd9, 1'b1, 2'd1);
        cycle(1'b0);
        nop(); cycle(1'b0); cycle(1'b0);
        set_d(5'd9, 1'b1, 2'd1, 5'd0, 1'b0, 2'd0, 5'd10, 1'b1, 2'd1);
        want(1'b0, 2'd3, 2'd0); cycle(1'b0);

        // ori $5 then two readers of $5
        set_d(5'd3, 1'b1, 2'd1, 5'd0, 1'b0, 2'd0, 5'd5, 1'b1, 2'd1);
        cycle(1'b0);
        set_d(5'd5, 1'b1, 2'd1, 5'd6, 1'b1, 2'd1, 5'd11, 1'b1, 2'd1);
        want(1'b0, 2'd0, 2'd0); cycle(1'b0);
        set_d(5'd5, 1'b1, 2'd1, 5'd0, 1'b0, 2'd0, 5'd12, 1'b1, 2'd1);
        want(1'b0, 2'd2, 2'd0); cycle(1'b0);

        // writes to $0 are never tracked
        set_d(5'd1, 1'b1, 2'd1, 5'd0, 1'b0, 2'd0, 5'd0, 1'b1, 2'd2);
        cycle(1'b0);
        set_d(5'd0, 1'b1, 2'd0, 5'd0, 1'b1, 2'd0, 5'd0, 1'b0, 2'd0);
        for (int i = 0; i < 3; i++) begin
            want(1'b0, 2'd0, 2'd0); cycle(1'b0);
        end

        // $7 in E (Tnew 2) hides $7 in M (Tnew 0); rs and rt both name $7
        nop(); for (int i = 0; i < 3; i++) cycle(1'b0);
        set_d(5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0, 5'd7, 1'b1, 2'd1);
        cycle(1'b0);
        set_d(5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0, 5'd7, 1'b1, 2'd2);
        cycle(1'b0);
        set_d(5'd7, 1'b1, 2'd1, 5'd7, 1'b1, 2'd1, 5'd0, 1'b0, 2'd0);
        want(1'b1, 2'd0, 2'd0); cycle(1'b0);
        want(1'b0, 2'd0, 2'd0); cycle(1'b0);
        want(1'b0, 2'd3, 2'd3); cycle(1'b0);

        // reset asserted in the first cycle of a lw stall
        nop(); for (int i = 0; i < 3; i++) cycle(1'b0);
        set_d(5'd29, 1'b1, 2'd1, 5'd0, 1'b0, 2'd0, 5'd8, 1'b1, 2'd2);
        cycle(1'b0);
        set_d(5'd8, 1'b1, 2'd0, 5'd0, 1'b1, 2'd0, 5'd0, 1'b0, 2'd0);
        Reset = 1'b1;
        want(1'b1, 2'd0, 2'd0); cycle(1'b0);
        Reset = 1'b0;
        want(1'b0, 2'd0, 2'd0); want_cnt(16'd0); cycle(1'b0);
        want(1'b0, 2'd0, 2'd0); cycle(1'b0);

        // counter saturation: a self-dependent Tnew=3 writer stalls 3 of every 4 cycles
        set_d(5'd8, 1'b1, 2'd0, 5'd0, 1'b0, 2'd0, 5'd8, 1'b1, 2'd3);
        while (mcnt != 16'hFFFF) cycle(1'b1);
        for (int i = 0; i < 8; i++) begin
            want_cnt(16'hFFFF); cycle(1'b0);
        end

        // random traffic over a small register set
        Reset = 1'b1; nop();
        want(1'b0, 2'd0, 2'd0); cycle(1'b0);
        Reset = 1'b0;
        for (int i = 0; i < 300; i++) begin
            set_d(5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)),
                  5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)),
                  5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
            Reset = ($urandom_range(0, 39) == 0);
            cycle(1'b0);
        end
        Reset = 1'b0;

        // final report
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
